// File: rtl/sample_pacer.sv
// sample_pacer: buffers ADC samples in a small circular FIFO and hands them to
// the DFT datapath as single-cycle sampleReady pulses. Consecutive pulses are
// separated by at least MIN_GAP idle cycles so each DFT update can finish.
// Samples that find the buffer full are dropped and counted (saturating).
//
// Timing model: the issue decision is taken in IDLE and registers the head
// sample into inputSample. The head entry is retired from the FIFO in the
// pulse cycle itself. So occupancy falls one cycle after the pulse, and a
// strobe landing on a pulse cycle with a full buffer still finds room.
module sample_pacer #(
    parameter int DATA_W  = 16,
    parameter int DEPTH   = 8,
    parameter int MIN_GAP = 250
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_W-1:0]        adcSample,
    input  logic                     adcStrobe,
    input  logic                     enable,
    input  logic                     busy,
    output logic [DATA_W-1:0]        inputSample,
    output logic                     sampleReady,
    output logic [$clog2(DEPTH):0]   fifoCount,
    output logic [7:0]               dropCount,
    input  logic                     dropClear
);

    localparam int AW = $clog2(DEPTH);
    localparam int GW = $clog2(MIN_GAP + 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_GAP  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [GW-1:0]       gap_q, gap_d;
    logic [AW:0]         wr_ptr_q, wr_ptr_d;
    logic [AW:0]         rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0]   sample_q, sample_d;
    logic                ready_q, ready_d;
    logic [7:0]          drop_q, drop_d;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic [AW:0]         occupancy;
    logic                fifo_full;
    logic                fifo_empty;
    logic                pop;
    logic                push;
    logic                drop;
    logic                issue;

    // Occupancy from the wrap-extended pointers; pop retires the issued entry.
    always_comb begin
        occupancy  = wr_ptr_q - rd_ptr_q;
        fifo_full  = (occupancy == (AW + 1)'(DEPTH));
        fifo_empty = (occupancy == '0);
        pop        = ready_q;
        push       = adcStrobe && (!fifo_full || pop);
        drop       = adcStrobe && !push;
        issue      = (state_q == S_IDLE) && enable && !busy && !fifo_empty;
    end

    // Pointer advance: write on accepted push, read on the pulse cycle.
    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
    end

    // Pacing FSM: decide issue in IDLE, then count out the idle gap.
    always_comb begin
        state_d  = state_q;
        gap_d    = gap_q;
        ready_d  = 1'b0;
        sample_d = sample_q;
        case (state_q)
            S_IDLE: begin
                if (issue) begin
                    sample_d = mem[rd_ptr_q[AW-1:0]];
                    ready_d  = 1'b1;
                    gap_d    = GW'(MIN_GAP);
                    state_d  = S_GAP;
                end
            end
            S_GAP: begin
                // Leaving on the last count gives exactly MIN_GAP low cycles.
                if (gap_q <= GW'(1)) begin
                    gap_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q - GW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                gap_d   = '0;
            end
        endcase
    end

    // Drop counter: saturates at 255; a clear coinciding with a drop leaves 1.
    always_comb begin
        drop_d = drop_q;
        if (dropClear) begin
            drop_d = {7'b0, drop};
        end else if (drop && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    // Sample storage; contents need no reset since the pointers gate validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q[AW-1:0]] <= adcSample;
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            gap_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            sample_q <= '0;
            ready_q  <= 1'b0;
            drop_q   <= '0;
        end else begin
            state_q  <= state_d;
            gap_q    <= gap_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            sample_q <= sample_d;
            ready_q  <= ready_d;
            drop_q   <= drop_d;
        end
    end

    assign inputSample = sample_q;
    assign sampleReady = ready_q;
    assign fifoCount   = occupancy;
    assign dropCount   = drop_q;

endmodule

// File: tb/tb_sample_pacer.sv
// Bench for sample_pacer: a queue-based reference model tracks the expected
// outputs every cycle, plus directed checks of the documented timing cases.
module tb_sample_pacer;

    localparam int DATA_W  = 16;
    localparam int DEPTH   = 8;
    localparam int MIN_GAP = 250;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [DATA_W-1:0] adcSample = '0;
    logic              adcStrobe = 1'b0;
    logic              enable = 1'b0;
    logic              busy = 1'b0;
    logic              dropClear = 1'b0;
    logic [DATA_W-1:0] inputSample;
    logic              sampleReady;
    logic [3:0]        fifoCount;
    logic [7:0]        dropCount;

    always #5 clk = ~clk;

    sample_pacer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .MIN_GAP(MIN_GAP)) dut (
        .clk         (clk),
        .rst         (rst),
        .adcSample   (adcSample),
        .adcStrobe   (adcStrobe),
        .enable      (enable),
        .busy        (busy),
        .inputSample (inputSample),
        .sampleReady (sampleReady),
        .fifoCount   (fifoCount),
        .dropCount   (dropCount),
        .dropClear   (dropClear)
    );

    int n_cmp = 0;
    int n_mis = 0;
    int cyc = 0;

    // Reference model state.
    logic [DATA_W-1:0] mq[$];
    bit                m_rdy = 1'b0;
    logic [DATA_W-1:0] m_smp = '0;
    int                m_drop = 0;
    int                next_dec = 0;

    // Observed pulses.
    int                p_cyc[$];
    logic [DATA_W-1:0] p_dat[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: model applies the rules to this cycle's inputs, then compare.
    task automatic step();
        bit pop;
        bit dec;
        bit drp;
        @(posedge clk);
        pop = m_rdy;
        dec = (cyc >= next_dec) && enable && !busy && (mq.size() != 0);
        if (dec) begin
            m_smp    = mq[0];
            next_dec = cyc + MIN_GAP + 1;
        end
        m_rdy = dec;
        if (pop) void'(mq.pop_front());
        drp = 1'b0;
        if (adcStrobe) begin
            if (mq.size() < DEPTH) mq.push_back(adcSample);
            else drp = 1'b1;
        end
        if (dropClear) m_drop = drp ? 1 : 0;
        else if (drp && m_drop < 255) m_drop++;
        cyc++;
        @(negedge clk);
        check_eq("sampleReady", 32'(sampleReady), 32'(m_rdy));
        check_eq("inputSample", 32'(inputSample), 32'(m_smp));
        check_eq("fifoCount", 32'(fifoCount), 32'(mq.size()));
        check_eq("dropCount", 32'(dropCount), 32'(m_drop));
        if (sampleReady === 1'b1) begin
            p_cyc.push_back(cyc);
            p_dat.push_back(inputSample);
            $display("pulse cycle=%0d sample=%04h fifo=%0d drops=%0d", cyc, inputSample, fifoCount, dropCount);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Asynchronous reset raised between edges; outputs must clear at once.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        check_eq("rst_inputSample", 32'(inputSample), 32'h0);
        check_eq("rst_sampleReady", 32'(sampleReady), 32'h0);
        check_eq("rst_fifoCount", 32'(fifoCount), 32'h0);
        check_eq("rst_dropCount", 32'(dropCount), 32'h0);
        mq.delete();
        m_rdy    = 1'b0;
        m_smp    = '0;
        m_drop   = 0;
        next_dec = 0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        $display("reset released at cycle %0d", cyc);
    endtask

    initial begin
        int t;
        int tb_low;
        logic [DATA_W-1:0] nxt;

        #2;
        do_reset();

        // Burst of 20 strobes, loaded while issue is disabled, then drained.
        enable = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            adcSample = DATA_W'(i);
            adcStrobe = 1'b1;
            step();
        end
        adcStrobe = 1'b0;
        check_eq("burst_drops", 32'(dropCount), 32'd12);
        p_cyc.delete(); p_dat.delete();
        enable = 1'b1;
        for (int k = 0; k < 3000 && p_cyc.size() < 8; k++) step();
        idle(300);
        check_eq("burst_pulse_count", 32'(p_cyc.size()), 32'd8);
        for (int i = 0; i < p_cyc.size(); i++) begin
            check_eq("burst_data", 32'(p_dat[i]), 32'(i + 1));
            if (i > 0) check_eq("burst_spacing", 32'(p_cyc[i] - p_cyc[i-1]), 32'(MIN_GAP + 1));
        end

        // Single strobe latency into an empty idle FIFO.
        p_cyc.delete(); p_dat.delete();
        t = cyc;
        adcSample = 16'h8000;
        adcStrobe = 1'b1;
        step();
        adcStrobe = 1'b0;
        check_eq("single_fifo_t1", 32'(fifoCount), 32'd1);
        idle(3);
        check_eq("single_fifo_t3", 32'(fifoCount), 32'd0);
        check_eq("single_pulse_count", 32'(p_cyc.size()), 32'd1);
        if (p_cyc.size() >= 1) begin
            check_eq("single_pulse_cycle", 32'(p_cyc[0]), 32'(t + 2));
            check_eq("single_pulse_data", 32'(p_dat[0]), 32'h8000);
        end
        idle(260);

        // busy held for 400 cycles with 3 samples queued.
        p_cyc.delete(); p_dat.delete();
        busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            adcSample = 16'h0A01 + DATA_W'(i);
            adcStrobe = 1'b1;
            step();
        end
        adcStrobe = 1'b0;
        idle(397);
        check_eq("busy_no_pulse", 32'(p_cyc.size()), 32'd0);
        busy = 1'b0;
        tb_low = cyc;
        for (int k = 0; k < 600 && p_cyc.size() < 2; k++) step();
        check_eq("busy_pulse_count", 32'(p_cyc.size()), 32'd2);
        if (p_cyc.size() >= 2) begin
            check_eq("busy_first_pulse", 32'(p_cyc[0]), 32'(tb_low + 1));
            check_eq("busy_second_pulse", 32'(p_cyc[1] - p_cyc[0]), 32'(MIN_GAP + 1));
        end
        idle(600);

        // Full FIFO with strobes landing on pulse cycles; 3*DEPTH wrap order.
        enable = 1'b0;
        dropClear = 1'b1;
        step();
        dropClear = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            adcSample = 16'h0B00 + DATA_W'(i);
            adcStrobe = 1'b1;
            step();
        end
        adcStrobe = 1'b0;
        check_eq("full_fifo", 32'(fifoCount), 32'd8);
        p_cyc.delete(); p_dat.delete();
        enable = 1'b1;
        step();
        nxt = 16'h0C00;
        for (int k = 0; k < 7000 && p_cyc.size() < 3 * DEPTH; k++) begin
            adcStrobe = sampleReady;
            adcSample = nxt;
            if (sampleReady) nxt = nxt + 16'd1;
            step();
            if (adcStrobe) check_eq("full_push_count", 32'(fifoCount), 32'd8);
        end
        adcStrobe = 1'b0;
        check_eq("full_no_drops", 32'(dropCount), 32'd0);
        check_eq("wrap_pulse_count", 32'(p_cyc.size()), 32'(3 * DEPTH));
        for (int i = 0; i < p_cyc.size(); i++) begin
            check_eq("wrap_order", 32'(p_dat[i]),
                     (i < DEPTH) ? 32'(16'h0B00 + i) : 32'(16'h0C00 + i - DEPTH));
        end

        // Drop saturation and clear-with-drop.
        enable = 1'b0;
        idle(MIN_GAP + 2);
        dropClear = 1'b1;
        step();
        dropClear = 1'b0;
        adcSample = 16'h0D0D;
        adcStrobe = 1'b1;
        idle(300);
        check_eq("drop_saturate", 32'(dropCount), 32'd255);
        dropClear = 1'b1;
        step();
        dropClear = 1'b0;
        adcStrobe = 1'b0;
        check_eq("drop_clear_with_drop", 32'(dropCount), 32'd1);

        // Reset mid-gap with 5 queued, then a fresh strobe.
        enable = 1'b1;
        idle(2 * (MIN_GAP + 1) + 100);
        check_eq("pre_reset_fifo", 32'(fifoCount), 32'd5);
        do_reset();
        p_cyc.delete(); p_dat.delete();
        t = cyc;
        adcSample = 16'h1234;
        adcStrobe = 1'b1;
        step();
        adcStrobe = 1'b0;
        idle(2);
        check_eq("post_reset_pulses", 32'(p_cyc.size()), 32'd1);
        if (p_cyc.size() >= 1) begin
            check_eq("post_reset_cycle", 32'(p_cyc[0]), 32'(t + 2));
            check_eq("post_reset_data", 32'(p_dat[0]), 32'h1234);
        end

        // Randomized traffic against the model, with one reset in the middle.
        for (int i = 0; i < 15000; i++) begin
            adcStrobe = ($urandom_range(0, 3) == 0);
            adcSample = DATA_W'($urandom);
            enable    = ($urandom_range(0, 15) != 0);
            busy      = ($urandom_range(0, 7) == 0);
            dropClear = ($urandom_range(0, 63) == 0);
            if (i == 7000) do_reset();
            step();
        end
        adcStrobe = 1'b0;
        dropClear = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
